// File: rtl/gps_ser_reader_pkg.sv
// Shared definitions for the GPS serial readback reader: source codes, op_8
// select indices (mirroring the generated kiwi.gen.vh) and the FSM state type.
package gps_ser_reader_pkg;

    localparam int GET_CHAN_IQ  = 0;
    localparam int GET_SRQ      = 1;
    localparam int GET_SNAPSHOT = 2;

    localparam int WORD_W = 16;
    localparam int POS_W  = $clog2(WORD_W);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DRAIN,
        ST_FIN
    } state_t;

    // Source code 3 has no dedicated select and reads the channel IQ register.
    function automatic logic [7:0] src_onehot(input logic [1:0] src);
        logic [7:0] oh;
        oh = 8'b0;
        if (src == 2'(GET_SRQ))
            oh[GET_SRQ] = 1'b1;
        else if (src == 2'(GET_SNAPSHOT))
            oh[GET_SNAPSHOT] = 1'b1;
        else
            oh[GET_CHAN_IQ] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/gps_ser_reader_pack.sv
// Packs serial bits MSB-first into 16-bit words on a valid/ready stream and
// flags a stall when the next bit would complete a word the consumer still holds.
module gps_ser_pack
    import gps_ser_reader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              bit_in,
    input  logic              bit_en,
    input  logic              last,
    input  logic              word_ready,
    output logic              stall,
    output logic              word_valid,
    output logic [WORD_W-1:0] word_data,
    output logic              word_last
);

    logic [WORD_W-1:0] acc;
    logic [WORD_W-1:0] acc_next;
    logic [POS_W-1:0]  pos;
    logic              completes;

    // The accumulator starts from zero each word, so a short final word
    // comes out right-aligned with its upper bits already clear.
    assign acc_next  = {acc[WORD_W-2:0], bit_in};
    assign completes = (pos == POS_W'(WORD_W - 1)) || last;
    assign stall     = completes && word_valid && !word_ready;

    always_ff @(posedge clk) begin
        // NOTE: every register here uses <= so all updates see pre-edge values.
        if (rst) begin
            acc        <= '0;
            pos        <= '0;
            word_valid <= 1'b0;
            word_data  <= '0;
            word_last  <= 1'b0;
        end else begin
            if (clear) begin
                acc <= '0;
                pos <= '0;
            end else if (bit_en) begin
                if (completes) begin
                    acc <= '0;
                    pos <= '0;
                end else begin
                    acc <= acc_next;
                    pos <= pos + POS_W'(1);
                end
            end

            if (bit_en && completes) begin
                word_valid <= 1'b1;
                word_data  <= acc_next;
                word_last  <= last;
            end else if (word_ready) begin
                word_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/gps_ser_reader.sv
// Host-side reader for the GPS bit-serial readback port: one rdReg load strobe,
// then one rdBit per bit, with the bits packed into a 16-bit word stream.
module gps_ser_reader
    import gps_ser_reader_pkg::*;
#(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_src,
    input  logic [CNT_W-1:0] req_nbits,
    output logic             rdReg,
    output logic             rdBit,
    output logic [7:0]       op_8,
    input  logic             ser,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [15:0]      word_data,
    output logic             word_last,
    output logic             done
);

    state_t           state;
    logic [CNT_W-1:0] nbits_q;
    logic [CNT_W-1:0] bit_cnt;
    logic             accept;
    logic             last_bit;
    logic             stall;

    assign accept   = req_valid && req_ready;
    assign last_bit = (bit_cnt == nbits_q - CNT_W'(1));

    // rdBit is decoded from state so the stall can react to word_ready
    // within the same cycle; ser is sampled on the edge that ends it.
    assign rdBit = (state == ST_SHIFT) && !stall;

    gps_ser_pack u_pack (
        .clk        (clk),
        .rst        (rst),
        .clear      (accept),
        .bit_in     (ser),
        .bit_en     (rdBit),
        .last       (last_bit),
        .word_ready (word_ready),
        .stall      (stall),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_last  (word_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            rdReg     <= 1'b0;
            op_8      <= '0;
            done      <= 1'b0;
            nbits_q   <= '0;
            bit_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        nbits_q   <= req_nbits;
                        bit_cnt   <= '0;
                        rdReg     <= 1'b1;
                        op_8      <= src_onehot(req_src);
                        req_ready <= 1'b0;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    rdReg <= 1'b0;
                    op_8  <= '0;
                    if (nbits_q == '0) begin
                        done  <= 1'b1;
                        state <= ST_FIN;
                    end else begin
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (rdBit) begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (last_bit)
                            state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (word_valid && word_ready) begin
                        done  <= 1'b1;
                        state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    done      <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gps_ser_reader.sv
// Directed self-checking bench for gps_ser_reader with a behavioural GPS-side
// shift register model and a negedge monitor logging strobes and words.
module tb_gps_ser_reader;

    localparam int CNT_W = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_src;
    logic [CNT_W-1:0] req_nbits;
    logic             rdReg;
    logic             rdBit;
    logic [7:0]       op_8;
    logic             ser;
    logic             word_valid;
    logic             word_ready;
    logic [15:0]      word_data;
    logic             word_last;
    logic             done;

    gps_ser_reader #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_src    (req_src),
        .req_nbits  (req_nbits),
        .rdReg      (rdReg),
        .rdBit      (rdBit),
        .op_8       (op_8),
        .ser        (ser),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_data  (word_data),
        .word_last  (word_last),
        .done       (done)
    );

    always #5 clk = ~clk;

    // GPS-side model: per-source data, MSB-aligned, loaded on rdReg.
    logic [63:0] sr;
    logic [63:0] data_iq, data_srq, data_snap;
    assign ser = sr[63];

    always @(posedge clk) begin
        if (rdReg) begin
            case (op_8)
                8'h02:   sr <= data_srq;
                8'h04:   sr <= data_snap;
                default: sr <= data_iq;
            endcase
        end else if (rdBit) begin
            sr <= sr << 1;
        end
    end

    // Monitor, sampled mid-cycle.
    int          cyc = 0;
    int          rdreg_cnt = 0, rdbit_cnt = 0, wcnt = 0, done_cnt = 0;
    int          op8_bad = 0, stab_bad = 0;
    int          last_req_cyc = 0, last_op8 = 0, last_rdbit_cyc = 0;
    int          rdreg_log [0:63];
    int          done_log  [0:63];
    logic [16:0] word_log  [0:63];
    logic        prev_hold = 1'b0;
    logic [16:0] prev_word = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (req_valid && req_ready)
            last_req_cyc <= cyc;
        if (rdReg) begin
            if (rdreg_cnt < 64) rdreg_log[rdreg_cnt] <= cyc;
            rdreg_cnt <= rdreg_cnt + 1;
            last_op8  <= int'(op_8);
        end
        if (op_8 != 8'h00 && !rdReg)
            op8_bad <= op8_bad + 1;
        if (rdBit) begin
            rdbit_cnt      <= rdbit_cnt + 1;
            last_rdbit_cyc <= cyc;
        end
        if (word_valid && word_ready) begin
            if (wcnt < 64) word_log[wcnt] <= {word_last, word_data};
            wcnt <= wcnt + 1;
        end
        if (done) begin
            if (done_cnt < 64) done_log[done_cnt] <= cyc;
            done_cnt <= done_cnt + 1;
        end
        if (!rst && prev_hold && (!word_valid || {word_last, word_data} != prev_word))
            stab_bad <= stab_bad + 1;
        prev_hold <= word_valid && !word_ready && !rst;
        prev_word <= {word_last, word_data};
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_req(input logic [1:0] src, input int n);
        int k;
        k = 0;
        req_src   = src;
        req_nbits = CNT_W'(n);
        req_valid = 1'b1;
        while (!req_ready && k < 200) begin
            tick(1);
            k++;
        end
        tick(1);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0, input int budget);
        int k;
        k = 0;
        while (done_cnt <= d0 && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, done_cnt - d0, 1);
    endtask

    int r0, b0, w0, d0, t, t1;

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_src    = 2'd0;
        req_nbits  = '0;
        word_ready = 1'b1;
        data_iq    = '0;
        data_srq   = '0;
        data_snap  = '0;
        tick(3);
        check("reset_outputs", {rdReg, rdBit, op_8, word_valid, word_data, word_last, done}, 0);
        check("reset_req_ready", req_ready, 1);
        rst = 1'b0;
        tick(2);

        // SRQ, N=5: bits 1,0,1,1,0 -> 0x0016
        data_srq = 64'b10110 << 59;
        r0 = rdreg_cnt; b0 = rdbit_cnt; w0 = wcnt; d0 = done_cnt;
        do_req(2'd1, 5);
        wait_done("srq_done", d0, 100);
        t = last_req_cyc;
        check("srq_rdreg_cnt", rdreg_cnt - r0, 1);
        check("srq_op8", last_op8, 8'h02);
        check("srq_rdreg_cyc", rdreg_log[r0] - t, 1);
        check("srq_rdbit_cnt", rdbit_cnt - b0, 5);
        check("srq_rdbit_last_cyc", last_rdbit_cyc - t, 6);
        check("srq_word_cnt", wcnt - w0, 1);
        check("srq_word0", word_log[w0], {1'b1, 16'h0016});
        check("srq_done_cyc", done_log[d0] - t, 8);
        tick(2);

        // Snapshot, N=40
        data_snap = 64'hA5A5_1234_56 << 24;
        r0 = rdreg_cnt; b0 = rdbit_cnt; w0 = wcnt; d0 = done_cnt;
        do_req(2'd2, 40);
        wait_done("snap_done", d0, 200);
        t = last_req_cyc;
        check("snap_op8", last_op8, 8'h04);
        check("snap_rdbit_cnt", rdbit_cnt - b0, 40);
        check("snap_word_cnt", wcnt - w0, 3);
        check("snap_word0", word_log[w0], {1'b0, 16'hA5A5});
        check("snap_word1", word_log[w0 + 1], {1'b0, 16'h1234});
        check("snap_word2", word_log[w0 + 2], {1'b1, 16'h0056});
        check("snap_done_cyc", done_log[d0] - t, 43);
        tick(2);

        // Backpressure, N=48
        data_srq   = 64'h0123_4567_89AB << 16;
        word_ready = 1'b0;
        b0 = rdbit_cnt; w0 = wcnt; d0 = done_cnt;
        do_req(2'd1, 48);
        for (int k = 0; k < 100 && !word_valid; k++) tick(1);
        tick(20);
        check("bp_rdbit_stalled", rdbit_cnt - b0, 31);
        check("bp_held_word", {word_valid, word_last, word_data}, {1'b1, 1'b0, 16'h0123});
        word_ready = 1'b1;
        wait_done("bp_done", d0, 200);
        check("bp_rdbit_cnt", rdbit_cnt - b0, 48);
        check("bp_word_cnt", wcnt - w0, 3);
        check("bp_word0", word_log[w0], {1'b0, 16'h0123});
        check("bp_word1", word_log[w0 + 1], {1'b0, 16'h4567});
        check("bp_word2", word_log[w0 + 2], {1'b1, 16'h89AB});
        tick(2);

        // N=0, source IQ
        r0 = rdreg_cnt; b0 = rdbit_cnt; w0 = wcnt; d0 = done_cnt;
        do_req(2'd0, 0);
        wait_done("n0_done", d0, 50);
        t = last_req_cyc;
        check("n0_rdreg_cnt", rdreg_cnt - r0, 1);
        check("n0_op8", last_op8, 8'h01);
        check("n0_rdbit_cnt", rdbit_cnt - b0, 0);
        check("n0_word_cnt", wcnt - w0, 0);
        check("n0_done_cyc", done_log[d0] - t, 2);
        tick(2);

        // Reset mid-SHIFT, then SRQ N=3 (bits 1,1,0 -> 0x0006)
        data_snap = 64'hFFFF_0000_FFFF_0000;
        b0 = rdbit_cnt;
        do_req(2'd2, 32);
        for (int k = 0; k < 100 && (rdbit_cnt - b0) < 7; k++) tick(1);
        rst = 1'b1;
        tick(1);
        check("midrst_outputs", {rdReg, rdBit, op_8, word_valid, word_data, word_last, done}, 0);
        check("midrst_req_ready", req_ready, 1);
        rst = 1'b0;
        tick(1);
        data_srq = 64'b110 << 61;
        b0 = rdbit_cnt; w0 = wcnt; d0 = done_cnt;
        do_req(2'd1, 3);
        wait_done("post_rst_done", d0, 100);
        check("post_rst_rdbit_cnt", rdbit_cnt - b0, 3);
        check("post_rst_word_cnt", wcnt - w0, 1);
        check("post_rst_word0", word_log[w0], {1'b1, 16'h0006});
        tick(2);

        // Back-to-back: SRQ N=16 then snapshot N=16 with req_valid held
        data_srq  = 64'hBEEF << 48;
        data_snap = 64'hC0DE << 48;
        r0 = rdreg_cnt; w0 = wcnt; d0 = done_cnt;
        req_src   = 2'd1;
        req_nbits = CNT_W'(16);
        req_valid = 1'b1;
        for (int k = 0; k < 100 && !req_ready; k++) tick(1);
        tick(1);
        t1 = last_req_cyc;
        req_src = 2'd2;
        for (int k = 0; k < 200 && rdreg_cnt < r0 + 2; k++) tick(1);
        req_valid = 1'b0;
        wait_done("b2b_done", d0 + 1, 200);
        check("b2b_done1_cyc", done_log[d0] - t1, 19);
        check("b2b_rdreg2_cyc", rdreg_log[r0 + 1] - done_log[d0], 2);
        check("b2b_op8_2", last_op8, 8'h04);
        check("b2b_word_cnt", wcnt - w0, 2);
        check("b2b_word0", word_log[w0], {1'b1, 16'hBEEF});
        check("b2b_word1", word_log[w0 + 1], {1'b1, 16'hC0DE});
        tick(2);

        check("op8_outside_rdreg", op8_bad, 0);
        check("word_stable_under_stall", stab_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
